// File: rtl/ifu_imem_rsp_pkg.sv
// rtl/ifu_imem_rsp_pkg.sv - shared widths, constants and response-entry type for the imem responder
package ifu_imem_rsp_pkg;

    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;
    localparam int CNT_W      = 3;

    // All-zero word is an illegal encoding, so the IFU traps on a bad fetch
    localparam logic [INSTR_SIZE-1:0] ILLEGAL_INSTR = 32'h0000_0000;

    // Byte address of RAM word 0, matching the IFU reset vector
    localparam logic [PC_SIZE-1:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] data;
        logic [CNT_W-1:0]      cnt;
    } rsp_entry_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - in-order response FIFO with per-entry latency countdown
module imem_rsp_fifo
    import ifu_imem_rsp_pkg::*;
#(
    parameter int OSTD    = 4,
    parameter int LATENCY = 2,
    localparam int PTR_W  = $clog2(OSTD),
    localparam int OCC_W  = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [INSTR_SIZE-1:0] push_data,
    input  logic                  pop,
    output logic                  head_ready,
    output logic [INSTR_SIZE-1:0] head_data,
    output logic [OCC_W-1:0]      occupancy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    rsp_entry_t       entries [OSTD];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave occupancy unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            occupancy <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage: load at the tail, count every non-zero latency counter down each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OSTD; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OSTD; i++) begin
                if (push && (tail_ptr == PTR_W'(i))) begin
                    entries[i].data <= push_data;
                    entries[i].cnt  <= CNT_INIT;
                end else if (entries[i].cnt != '0) begin
                    entries[i].cnt <= entries[i].cnt - 1'b1;
                end
            end
        end
    end

    assign head_ready = (occupancy != '0) && (entries[head_ptr].cnt == '0);
    assign head_data  = entries[head_ptr].data;

endmodule

// File: rtl/ifu_imem_rsp.sv
// rtl/ifu_imem_rsp.sv - IFU instruction-memory responder (optional random backpressure: IMEM_RAND_STALL_EN)
module ifu_imem_rsp #(
    parameter int                 PC_SIZE    = ifu_imem_rsp_pkg::PC_SIZE,
    parameter int                 INSTR_SIZE = ifu_imem_rsp_pkg::INSTR_SIZE,
    parameter int                 DEPTH_LOG2 = 12,
    parameter logic [PC_SIZE-1:0] BASE_ADDR  = ifu_imem_rsp_pkg::DEFAULT_BASE_ADDR,
    parameter int                 LATENCY    = 2,
    parameter int                 OSTD       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [INSTR_SIZE-1:0] prog_wdata,
    output logic                  imem_err
);

    localparam int               OCC_W     = $clog2(OSTD) + 1;
    localparam logic [OCC_W-1:0] OSTD_OCC  = OCC_W'(OSTD);
    localparam logic [PC_SIZE:0] WIN_BYTES = (PC_SIZE + 1)'(1) << (DEPTH_LOG2 + 2);

    logic [INSTR_SIZE-1:0] mem [1 << DEPTH_LOG2];

    logic                  ready_en;
    logic                  stall;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  fetch_legal;
    logic                  head_ready;
    logic [OCC_W-1:0]      occupancy;
    logic [PC_SIZE-1:0]    off;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [INSTR_SIZE-1:0] fetch_data;
    logic [INSTR_SIZE-1:0] head_data;

    // Address decode: word-aligned offset inside the RAM window is legal
    assign off         = ifu_req_pc - BASE_ADDR;
    assign fetch_legal = (off[1:0] == 2'b00) && ({1'b0, off} < WIN_BYTES);
    assign word_idx    = off[DEPTH_LOG2+1:2];
    assign fetch_data  = fetch_legal ? mem[word_idx] : ifu_imem_rsp_pkg::ILLEGAL_INSTR;

`ifdef IMEM_RAND_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) used as a backpressure source
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Hold off requests until the first clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    // No full-bypass: a pop in a full cycle does not open the request port that same cycle
    assign ifu_req_ready = ready_en && !stall && (occupancy < OSTD_OCC);
    assign req_fire      = ifu_req_valid && ifu_req_ready;

    assign ifu_rsp_valid = head_ready;
    assign ifu_rsp_instr = head_ready ? head_data : '0;
    assign rsp_fire      = ifu_rsp_valid && ifu_rsp_ready;

    // Program-load port; the fetch read above sees the pre-write word in a colliding cycle
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_wdata;
    end

    // Sticky flag for any misaligned or out-of-window fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        imem_err <= 1'b0;
        else if (req_fire && !fetch_legal) imem_err <= 1'b1;
    end

    imem_rsp_fifo #(
        .OSTD    (OSTD),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (req_fire),
        .push_data  (fetch_data),
        .pop        (rsp_fire),
        .head_ready (head_ready),
        .head_data  (head_data),
        .occupancy  (occupancy)
    );

endmodule

// File: tb/tb_ifu_imem_rsp.sv
// tb/tb_ifu_imem_rsp.sv - self-checking bench for ifu_imem_rsp with a queue/timestamp reference model
module tb_ifu_imem_rsp;

    localparam int          LAT  = 2;
    localparam int          OSTD = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc = '0;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready = 1'b1;
    logic [31:0] ifu_rsp_instr;
    logic        prog_we = 1'b0;
    logic [11:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic        imem_err;

    always #5 clk = ~clk;

    ifu_imem_rsp dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .imem_err      (imem_err)
    );

    int vec    = 0;
    int miscmp = 0;

    // Reference model: memory image, in-order queue of {data, cycle it becomes visible}
    logic [31:0] mmem [0:4095];
    logic [31:0] q_data [$];
    int          q_t [$];
    logic        m_err = 1'b0;
    logic        m_ready_en = 1'b0;
    int          cyc = 0;
    logic        m_acc, m_pop;
    logic [31:0] m_off;

    function automatic logic e_ready();
        return m_ready_en && (q_data.size() < OSTD);
    endfunction

    function automatic logic e_valid();
        return (q_data.size() > 0) && (cyc >= q_t[0]);
    endfunction

    function automatic logic [31:0] e_instr();
        return e_valid() ? q_data[0] : 32'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_data.delete();
            q_t.delete();
            m_err      = 1'b0;
            m_ready_en = 1'b0;
        end else begin
            m_acc = ifu_req_valid && e_ready();
            m_pop = e_valid() && ifu_rsp_ready;
            if (m_pop) begin
                void'(q_data.pop_front());
                void'(q_t.pop_front());
            end
            if (m_acc) begin
                m_off = ifu_req_pc - BASE;
                if ((m_off % 4 == 0) && (m_off < 32'h4000)) begin
                    q_data.push_back(mmem[m_off[13:2]]);
                end else begin
                    q_data.push_back(32'h0);
                    m_err = 1'b1;
                end
                q_t.push_back(cyc + LAT);
            end
            if (prog_we) mmem[prog_addr] = prog_wdata;
            m_ready_en = 1'b1;
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b1;
        prog_we       = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            vec++; if (ifu_req_ready !== 1'b0) begin miscmp++; $display("FAIL reset_ready got %b want 0", ifu_req_ready); end
            vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL reset_valid got %b want 0", ifu_rsp_valid); end
            vec++; if (ifu_rsp_instr !== 32'h0) begin miscmp++; $display("FAIL reset_instr got %h want 0", ifu_rsp_instr); end
            vec++; if (imem_err !== 1'b0) begin miscmp++; $display("FAIL reset_err got %b want 0", imem_err); end
        end
        rst = 1'b1;
        step();
        vec++; if (ifu_req_ready !== 1'b1) begin miscmp++; $display("FAIL release_ready got %b want 1", ifu_req_ready); end
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 12'(i);
            prog_wdata = (i < 4) ? 32'((i + 1) * 32'h11) : $urandom;
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic test_single_latency();
        idle(2);
        ifu_req_valid = 1'b1;
        ifu_req_pc    = BASE;
        step();
        ifu_req_valid = 1'b0;
        vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL lat_early got %b want 0", ifu_rsp_valid); end
        step();
        vec++; if (ifu_rsp_valid !== 1'b1) begin miscmp++; $display("FAIL lat_valid got %b want 1", ifu_rsp_valid); end
        vec++; if (ifu_rsp_instr !== 32'h11) begin miscmp++; $display("FAIL lat_instr got %h want 00000011", ifu_rsp_instr); end
        step();
        vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL lat_after got %b want 0", ifu_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
        idle(2);
        for (int k = 0; k < 7; k++) begin
            ifu_req_valid = (k < 4);
            ifu_req_pc    = BASE + 32'(4 * k);
            vec++; if (ifu_req_ready !== 1'b1) begin miscmp++; $display("FAIL b2b_ready k=%0d got %b want 1", k, ifu_req_ready); end
            if (k >= 2 && k < 6) begin
                vec++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_instr !== exp[k-2])
                    begin miscmp++; $display("FAIL b2b_rsp k=%0d got %b/%h want 1/%h", k, ifu_rsp_valid, ifu_rsp_instr, exp[k-2]); end
            end else begin
                vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL b2b_idle k=%0d got %b want 0", k, ifu_rsp_valid); end
            end
            step();
        end
        ifu_req_valid = 1'b0;
    endtask

    task automatic test_full_stall();
        int          acc = 0;
        logic        sent = 1'b0;
        logic [31:0] got [$];
        logic [31:0] exp [5];
        idle(3);
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44; exp[4] = mmem[4];
        ifu_rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ifu_req_valid = 1'b1;
            ifu_req_pc    = BASE + 32'(4 * acc);
            vec++; if (ifu_req_ready !== (acc < 4)) begin miscmp++; $display("FAIL full_ready k=%0d got %b want %b", k, ifu_req_ready, acc < 4); end
            if (k >= 2) begin
                vec++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_instr !== 32'h11)
                    begin miscmp++; $display("FAIL full_hold k=%0d got %b/%h want 1/00000011", k, ifu_rsp_valid, ifu_rsp_instr); end
            end
            if (ifu_req_ready) acc++;
            step();
        end
        vec++; if (acc !== 4) begin miscmp++; $display("FAIL full_accepts got %0d want 4", acc); end
        ifu_rsp_ready = 1'b1;
        ifu_req_pc    = BASE + 32'h10;
        for (int k = 0; k < 12; k++) begin
            if (sent) ifu_req_valid = 1'b0;
            vec++; if (ifu_req_ready !== e_ready()) begin miscmp++; $display("FAIL drain_ready k=%0d got %b want %b", k, ifu_req_ready, e_ready()); end
            vec++; if (ifu_rsp_valid !== e_valid() || ifu_rsp_instr !== e_instr())
                begin miscmp++; $display("FAIL drain_rsp k=%0d got %b/%h want %b/%h", k, ifu_rsp_valid, ifu_rsp_instr, e_valid(), e_instr()); end
            if (ifu_rsp_valid) got.push_back(ifu_rsp_instr);
            if (ifu_req_valid && ifu_req_ready) sent = 1'b1;
            step();
        end
        ifu_req_valid = 1'b0;
        vec++; if (got.size() !== 5) begin miscmp++; $display("FAIL drain_count got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vec++; if (got[i] !== exp[i]) begin miscmp++; $display("FAIL drain_order i=%0d got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        pcs[0] = BASE + 32'h2; pcs[1] = BASE + 32'h4000; pcs[2] = BASE + 32'h8;
        exp[0] = 32'h0;        exp[1] = 32'h0;           exp[2] = 32'h33;
        idle(2);
        for (int k = 0; k < 8; k++) begin
            ifu_req_valid = (k < 3);
            if (k < 3) ifu_req_pc = pcs[k];
            vec++; if (imem_err !== (k >= 1)) begin miscmp++; $display("FAIL err_flag k=%0d got %b want %b", k, imem_err, k >= 1); end
            if (k >= 2 && k < 5) begin
                vec++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_instr !== exp[k-2])
                    begin miscmp++; $display("FAIL illegal_rsp k=%0d got %b/%h want 1/%h", k, ifu_rsp_valid, ifu_rsp_instr, exp[k-2]); end
            end
            step();
        end
        ifu_req_valid = 1'b0;
    endtask

    task automatic test_read_before_write();
        idle(2);
        prog_we       = 1'b1;
        prog_addr     = 12'h0;
        prog_wdata    = 32'hDEAD_BEEF;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = BASE;
        step();
        prog_we       = 1'b0;
        ifu_req_valid = 1'b0;
        step();
        vec++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_instr !== 32'h11)
            begin miscmp++; $display("FAIL rbw_old got %b/%h want 1/00000011", ifu_rsp_valid, ifu_rsp_instr); end
        step();
        ifu_req_valid = 1'b1;
        step();
        ifu_req_valid = 1'b0;
        step();
        vec++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_instr !== 32'hDEAD_BEEF)
            begin miscmp++; $display("FAIL rbw_new got %b/%h want 1/deadbeef", ifu_rsp_valid, ifu_rsp_instr); end
        step();
    endtask

    task automatic test_reset_midflight();
        idle(2);
        ifu_rsp_ready = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = BASE + 32'h8;
        step();
        ifu_req_pc    = BASE + 32'hC;
        step();
        ifu_req_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL midrst_valid got %b want 0", ifu_rsp_valid); end
        vec++; if (ifu_req_ready !== 1'b0) begin miscmp++; $display("FAIL midrst_ready got %b want 0", ifu_req_ready); end
        vec++; if (imem_err !== 1'b0) begin miscmp++; $display("FAIL midrst_err got %b want 0", imem_err); end
        step();
        step();
        rst           = 1'b1;
        ifu_rsp_ready = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL stale_rsp k=%0d got %b want 0", k, ifu_rsp_valid); end
            vec++; if (ifu_req_ready !== 1'b1) begin miscmp++; $display("FAIL post_ready k=%0d got %b want 1", k, ifu_req_ready); end
            step();
        end
        ifu_req_valid = 1'b1;
        ifu_req_pc    = BASE + 32'h4;
        step();
        ifu_req_valid = 1'b0;
        vec++; if (ifu_rsp_valid !== 1'b0) begin miscmp++; $display("FAIL post_early got %b want 0", ifu_rsp_valid); end
        step();
        vec++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_instr !== 32'h22)
            begin miscmp++; $display("FAIL post_fetch got %b/%h want 1/00000022", ifu_rsp_valid, ifu_rsp_instr); end
        step();
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            vec++; if (ifu_req_ready !== e_ready()) begin miscmp++; $display("FAIL rnd_ready k=%0d got %b want %b", k, ifu_req_ready, e_ready()); end
            vec++; if (ifu_rsp_valid !== e_valid() || ifu_rsp_instr !== e_instr())
                begin miscmp++; $display("FAIL rnd_rsp k=%0d got %b/%h want %b/%h", k, ifu_rsp_valid, ifu_rsp_instr, e_valid(), e_instr()); end
            vec++; if (imem_err !== m_err) begin miscmp++; $display("FAIL rnd_err k=%0d got %b want %b", k, imem_err, m_err); end
            r             = int'($urandom_range(0, 31));
            ifu_req_valid = ($urandom_range(0, 2) != 0);
            if (r == 0)      ifu_req_pc = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
            else if (r == 1) ifu_req_pc = BASE - 32'h4;
            else if (r == 2) ifu_req_pc = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 15));
            else             ifu_req_pc = BASE + 32'(4 * $urandom_range(0, 63));
            ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            prog_we       = ($urandom_range(0, 7) == 0);
            prog_addr     = 12'($urandom_range(0, 63));
            prog_wdata    = $urandom;
            step();
        end
        idle(8);
    endtask

    initial begin
        test_reset();
        load_program();
        test_single_latency();
        test_back_to_back();
        test_full_stall();
        test_illegal();
        test_read_before_write();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
